// File: rtl/body_rate_controller.sv
// body_rate_controller
//   Rate-loop PID stage. On a start_signal rising edge (accepted only when
//   idle) the six rate inputs and the throttle are latched, then a PID is run
//   for roll, pitch and yaw in turn through a single shared multiplier. The
//   limited corrections and the latched throttle are published together with
//   a one-cycle complete_signal pulse and held until the next run completes.
//
//   Ports
//     us_clk, reset         clock / synchronous active-high reset
//     start_signal          rising edge starts a run (ignored while busy)
//     integ_clear           zeroes all integrators when idle
//     throttle_rate_in      throttle passed through to throttle_rate_out
//     *_target_rate         signed Q12.4 target rates
//     *_rate_actual         signed Q12.4 gyro rates
//     throttle_rate_out     latched throttle, updated with the PID outputs
//     *_pid_out             signed Q12.4 limited corrections
//     active_signal         high while a run is in progress
//     complete_signal       one-cycle pulse when the outputs update
module body_rate_controller #(
    parameter logic signed [15:0] KP_MULT     = 16'sd8,
    parameter int unsigned        KP_SHIFT    = 3,
    parameter logic signed [15:0] KI_MULT     = 16'sd1,
    parameter int unsigned        KI_SHIFT    = 4,
    parameter logic signed [15:0] KD_MULT     = 16'sd4,
    parameter int unsigned        KD_SHIFT    = 3,
    parameter logic signed [15:0] INTEG_LIMIT = 16'sd1600,
    parameter logic signed [15:0] OUT_LIMIT   = 16'sd3200
) (
    input  logic               us_clk,
    input  logic               reset,
    input  logic               start_signal,
    input  logic               integ_clear,
    input  logic        [15:0] throttle_rate_in,
    input  logic signed [15:0] roll_target_rate,
    input  logic signed [15:0] pitch_target_rate,
    input  logic signed [15:0] yaw_target_rate,
    input  logic signed [15:0] roll_rate_actual,
    input  logic signed [15:0] pitch_rate_actual,
    input  logic signed [15:0] yaw_rate_actual,
    output logic        [15:0] throttle_rate_out,
    output logic signed [15:0] roll_pid_out,
    output logic signed [15:0] pitch_pid_out,
    output logic signed [15:0] yaw_pid_out,
    output logic               active_signal,
    output logic               complete_signal
);

    typedef enum logic [2:0] {
        S_WAIT, S_LATCH, S_ERR, S_PTERM, S_ITERM, S_DTERM, S_SUM, S_DONE
    } state_t;

    state_t             state_q;
    logic [1:0]         axis_q;
    logic               start_q;
    logic        [15:0] thr_q;
    logic signed [15:0] tgt_q   [3];
    logic signed [15:0] act_q   [3];
    logic signed [15:0] integ_q [3];
    logic signed [15:0] prev_q  [3];
    logic signed [15:0] hold_q  [3];
    logic signed [15:0] err_q, p_q, d_q;

    logic signed [16:0] err_diff, d_diff, mul_a;
    logic signed [15:0] mul_b;
    logic signed [32:0] prod;
    logic signed [31:0] isum;
    logic signed [17:0] ssum;
    logic signed [15:0] err_d, p_d, integ_d, d_d, sum_d;
    logic               start_edge;

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)       return 16'sh7fff;
        else if (v < -33'sd32768) return 16'sh8000;
        else                      return v[15:0];
    endfunction

    assign start_edge = start_signal & ~start_q;

    // One multiplier: P and I both scale err, D scales the 17-bit error delta.
    always_comb begin
        err_diff = 17'(tgt_q[axis_q]) - 17'(act_q[axis_q]);
        d_diff   = 17'(err_q) - 17'(prev_q[axis_q]);
        mul_a    = 17'(err_q);
        mul_b    = KP_MULT;
        case (state_q)
            S_ITERM: mul_b = KI_MULT;
            S_DTERM: begin
                mul_a = d_diff;
                mul_b = KD_MULT;
            end
            default: ;
        endcase
        prod  = 33'(mul_a) * 33'(mul_b);

        err_d = sat16(33'(err_diff));
        p_d   = sat16(prod >>> KP_SHIFT);
        d_d   = sat16(prod >>> KD_SHIFT);

        isum = 32'(integ_q[axis_q]) + 32'(prod >>> KI_SHIFT);
        if (isum > 32'(INTEG_LIMIT))       integ_d = INTEG_LIMIT;
        else if (isum < -32'(INTEG_LIMIT)) integ_d = -INTEG_LIMIT;
        else                               integ_d = isum[15:0];

        ssum = 18'(p_q) + 18'(integ_q[axis_q]) + 18'(d_q);
        if (ssum > 18'(OUT_LIMIT))       sum_d = OUT_LIMIT;
        else if (ssum < -18'(OUT_LIMIT)) sum_d = -OUT_LIMIT;
        else                             sum_d = ssum[15:0];
    end

    always_ff @(posedge us_clk) begin
        if (reset) begin
            state_q           <= S_WAIT;
            axis_q            <= '0;
            start_q           <= 1'b0;
            thr_q             <= '0;
            err_q             <= '0;
            p_q               <= '0;
            d_q               <= '0;
            throttle_rate_out <= '0;
            roll_pid_out      <= '0;
            pitch_pid_out     <= '0;
            yaw_pid_out       <= '0;
            active_signal     <= 1'b0;
            complete_signal   <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                tgt_q[i]   <= '0;
                act_q[i]   <= '0;
                integ_q[i] <= '0;
                prev_q[i]  <= '0;
                hold_q[i]  <= '0;
            end
        end else begin
            start_q <= start_signal;
            case (state_q)
                S_WAIT: begin
                    complete_signal <= 1'b0;
                    if (integ_clear)
                        for (int unsigned i = 0; i < 3; i++) integ_q[i] <= '0;
                    if (start_edge) begin
                        state_q       <= S_LATCH;
                        active_signal <= 1'b1;
                    end
                end
                S_LATCH: begin
                    tgt_q[0] <= roll_target_rate;
                    tgt_q[1] <= pitch_target_rate;
                    tgt_q[2] <= yaw_target_rate;
                    act_q[0] <= roll_rate_actual;
                    act_q[1] <= pitch_rate_actual;
                    act_q[2] <= yaw_rate_actual;
                    thr_q    <= throttle_rate_in;
                    axis_q   <= '0;
                    state_q  <= S_ERR;
                end
                S_ERR: begin
                    err_q   <= err_d;
                    state_q <= S_PTERM;
                end
                S_PTERM: begin
                    p_q     <= p_d;
                    state_q <= S_ITERM;
                end
                S_ITERM: begin
                    integ_q[axis_q] <= integ_d;
                    state_q         <= S_DTERM;
                end
                S_DTERM: begin
                    d_q     <= d_d;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    hold_q[axis_q] <= sum_d;
                    prev_q[axis_q] <= err_q;
                    if (axis_q == 2'd2) begin
                        axis_q  <= '0;
                        state_q <= S_DONE;
                    end else begin
                        axis_q  <= axis_q + 2'd1;
                        state_q <= S_ERR;
                    end
                end
                S_DONE: begin
                    roll_pid_out      <= hold_q[0];
                    pitch_pid_out     <= hold_q[1];
                    yaw_pid_out       <= hold_q[2];
                    throttle_rate_out <= thr_q;
                    active_signal     <= 1'b0;
                    complete_signal   <= 1'b1;
                    state_q           <= S_WAIT;
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

endmodule
